// File: rtl/nios_cpu_oci_trace_capture.sv
// OCI trace capture: snoops the trace packer, queues each flushed word with its frame count,
// and sequences end-of-test draining. Optional per-entry parity via NIOS_OCI_TRACE_PARITY_EN.
module nios_cpu_oci_trace_capture #(
  parameter int BUF_W  = 30,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = 16,
  parameter int STAT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [BUF_W-1:0]         dct_buffer,
  input  logic [CNT_W-1:0]         dct_count,
  input  logic                     test_ending,
  input  logic                     test_has_ended,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [BUF_W-1:0]         rd_data,
  output logic [CNT_W-1:0]         rd_count,
  output logic                     rd_parity,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [STAT_W-1:0]        drop_count,
  output logic [STAT_W-1:0]        capture_count,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {RUN, DRAIN, ENDED} state_t;

  state_t           state;
  logic [BUF_W-1:0] buf_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ending_q;
  logic [LW-1:0]    wr_ptr;
  logic [LW-1:0]    rd_ptr;
  logic [BUF_W-1:0] mem_buf [DEPTH];
  logic [CNT_W-1:0] mem_cnt [DEPTH];

  logic             flush_ev;
  logic             partial_ev;
  logic             ending_rise;
  logic             push_req;
  logic             push_ok;
  logic             pop;
  logic             full;
  logic [BUF_W-1:0] push_buf;
  logic [CNT_W-1:0] push_cnt;

  assign fifo_level  = wr_ptr - rd_ptr;
  assign rd_valid    = (fifo_level != '0);
  assign full        = (fifo_level == LW'(DEPTH));
  assign pop         = rd_valid & rd_ready;

  // A flush is the packer's count dropping to zero; the word it held is still in buf_q/cnt_q.
  assign ending_rise = test_ending & ~ending_q;
  assign flush_ev    = (state == RUN) && (cnt_q != '0) && (dct_count == '0);
  assign partial_ev  = (state == RUN) && ending_rise && (dct_count != '0);
  assign push_req    = flush_ev | partial_ev;
  assign push_ok     = push_req & (~full | pop);
  assign push_buf    = flush_ev ? buf_q : dct_buffer;
  assign push_cnt    = flush_ev ? cnt_q : dct_count;

  assign rd_data  = rd_valid ? mem_buf[rd_ptr[AW-1:0]] : '0;
  assign rd_count = rd_valid ? mem_cnt[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_buf[wr_ptr[AW-1:0]] <= push_buf;
      mem_cnt[wr_ptr[AW-1:0]] <= push_cnt;
    end
  end

`ifdef NIOS_OCI_TRACE_PARITY_EN
  logic mem_par [DEPTH];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_par[wr_ptr[AW-1:0]] <= ^{push_cnt, push_buf};
    end
  end

  assign rd_parity = rd_valid & mem_par[rd_ptr[AW-1:0]];
`else
  assign rd_parity = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q         <= '0;
      cnt_q         <= '0;
      ending_q      <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      overflow      <= 1'b0;
      drop_count    <= '0;
      capture_count <= '0;
    end else begin
      buf_q    <= dct_buffer;
      cnt_q    <= dct_count;
      ending_q <= test_ending;
      if (push_ok) begin
        wr_ptr <= wr_ptr + LW'(1);
        if (capture_count != '1) capture_count <= capture_count + STAT_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + LW'(1);
      end
      // Statistics saturate so a long run never reports a misleadingly small number.
      if (push_req && !push_ok) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + STAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      done  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (test_has_ended) begin
            state <= ENDED;
            done  <= 1'b1;
          end else if (ending_rise) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (test_has_ended || (fifo_level == '0)) begin
            state <= ENDED;
            done  <= 1'b1;
          end
        end
        ENDED: begin
          done <= 1'b1;
        end
        default: begin
          state <= RUN;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nios_cpu_oci_trace_capture.sv
// Scoreboard bench for nios_cpu_oci_trace_capture: directed captures are queued as expected
// entries and a negedge monitor checks every accepted pop against the queue head.
module tb_nios_cpu_oci_trace_capture;

  localparam int BUF_W  = 30;
  localparam int CNT_W  = 4;
  localparam int DEPTH  = 16;
  localparam int STAT_W = 16;
  localparam int LW     = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [CNT_W-1:0] c;
    logic [BUF_W-1:0] d;
  } entry_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [BUF_W-1:0]  dct_buffer;
  logic [CNT_W-1:0]  dct_count;
  logic              test_ending;
  logic              test_has_ended;
  logic              rd_valid;
  logic              rd_ready;
  logic [BUF_W-1:0]  rd_data;
  logic [CNT_W-1:0]  rd_count;
  logic              rd_parity;
  logic [LW-1:0]     fifo_level;
  logic              overflow;
  logic [STAT_W-1:0] drop_count;
  logic [STAT_W-1:0] capture_count;
  logic              done;

  int     total = 0;
  int     bad   = 0;
  entry_t sb[$];

  nios_cpu_oci_trace_capture #(
    .BUF_W(BUF_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .STAT_W(STAT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .test_ending(test_ending), .test_has_ended(test_has_ended),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_count(rd_count),
    .rd_parity(rd_parity), .fifo_level(fifo_level), .overflow(overflow),
    .drop_count(drop_count), .capture_count(capture_count), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic exp_parity(input logic [CNT_W-1:0] c, input logic [BUF_W-1:0] d);
`ifdef NIOS_OCI_TRACE_PARITY_EN
    return ^{c, d};
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One flush: count goes non-zero for a cycle, then drops to zero.
  task automatic applyStimulus(input logic [CNT_W-1:0] c, input logic [BUF_W-1:0] d,
                               input bit accept, input bit pop_same);
    dct_buffer = d;
    dct_count  = c;
    tick();
    dct_count = '0;
    if (pop_same) rd_ready = 1'b1;
    if (accept) sb.push_back({c, d});
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic drain(input int n);
    rd_ready = 1'b1;
    repeat (n) tick();
    rd_ready = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    checkOutput({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
    checkOutput({tag, "_rd_data"}, 64'(rd_data), 64'd0);
    checkOutput({tag, "_rd_count"}, 64'(rd_count), 64'd0);
    checkOutput({tag, "_rd_parity"}, 64'(rd_parity), 64'd0);
    checkOutput({tag, "_level"}, 64'(fifo_level), 64'd0);
    checkOutput({tag, "_overflow"}, 64'(overflow), 64'd0);
    checkOutput({tag, "_drops"}, 64'(drop_count), 64'd0);
    checkOutput({tag, "_captures"}, 64'(capture_count), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
  endtask

  // Monitor: every handshake observed must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset_n && rd_valid && rd_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_pop", 64'(rd_data), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        entry_t e;
        e = sb.pop_front();
        checkOutput("pop_count", 64'(rd_count), 64'(e.c));
        checkOutput("pop_data", 64'(rd_data), 64'(e.d));
        checkOutput("pop_parity", 64'(rd_parity), 64'(exp_parity(e.c, e.d)));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0; dct_buffer = '0; dct_count = '0;
    test_ending = 1'b0; test_has_ended = 1'b0; rd_ready = 1'b0;
    repeat (2) tick();
    check_zero("reset");
    reset_n = 1'b1;
    tick();

    // Single flush 0->3->0 shows up one cycle after the drop.
    dct_buffer = 30'h15555555;
    dct_count  = 4'd3;
    tick();
    dct_count = '0;
    sb.push_back({4'd3, 30'h15555555});
    tick();
    checkOutput("t1_rd_valid", 64'(rd_valid), 64'd1);
    checkOutput("t1_rd_count", 64'(rd_count), 64'd3);
    checkOutput("t1_rd_data", 64'(rd_data), 64'h15555555);
    checkOutput("t1_captures", 64'(capture_count), 64'd1);
    drain(1);

    // Fill to 16, then a 17th flush is dropped.
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(CNT_W'((i % 15) + 1), BUF_W'(32'h100 + i), 1'b1, 1'b0);
    applyStimulus(4'd7, 30'h0ABCDEF, 1'b0, 1'b0);
    checkOutput("t2_level", 64'(fifo_level), 64'd16);
    checkOutput("t2_overflow", 64'(overflow), 64'd1);
    checkOutput("t2_drops", 64'(drop_count), 64'd1);
    checkOutput("t2_captures", 64'(capture_count), 64'd17);
    drain(DEPTH);
    checkOutput("t2_empty", 64'(fifo_level), 64'd0);

    // Full FIFO with a pop in the flush cycle: push accepted, lands last.
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(CNT_W'((i % 15) + 1), BUF_W'(32'h200 + i), 1'b1, 1'b0);
    applyStimulus(4'd15, 30'h3FFFFFFF, 1'b1, 1'b1);
    checkOutput("t4_level", 64'(fifo_level), 64'd16);
    checkOutput("t4_drops", 64'(drop_count), 64'd1);
    checkOutput("t4_captures", 64'(capture_count), 64'd34);
    drain(DEPTH);

    // Partial word on test_ending, then drain to done.
    applyStimulus(4'd1, 30'h00000AA, 1'b1, 1'b0);
    dct_buffer = 30'h0000123;
    dct_count  = 4'd2;
    tick();
    test_ending = 1'b1;
    sb.push_back({4'd2, 30'h0000123});
    tick();
    checkOutput("t3_level", 64'(fifo_level), 64'd2);
    checkOutput("t3_captures", 64'(capture_count), 64'd36);
    checkOutput("t3_not_done", 64'(done), 64'd0);
    dct_count = '0;
    repeat (2) tick();
    test_ending = 1'b0;
    checkOutput("t3_no_flush_in_drain", 64'(capture_count), 64'd36);
    drain(2);
    for (int i = 0; i < 8 && !done; i++) tick();
    checkOutput("t3_done", 64'(done), 64'd1);

    // Hard stop with 5 queued, then reset mid-read.
    reset_n = 1'b0;
    sb.delete();
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 5; i++)
      applyStimulus(CNT_W'(i + 1), BUF_W'(32'h300 + i), 1'b1, 1'b0);
    test_has_ended = 1'b1;
    tick();
    checkOutput("t5_done", 64'(done), 64'd1);
    checkOutput("t5_level", 64'(fifo_level), 64'd5);
    applyStimulus(4'd3, 30'h0000077, 1'b0, 1'b0);
    checkOutput("t5_no_capture", 64'(capture_count), 64'd5);
    drain(3);
    checkOutput("t5_remaining", 64'(fifo_level), 64'd2);
    rd_ready = 1'b1;
    reset_n  = 1'b0;
    sb.delete();
    #1;
    check_zero("midreset");
    tick();
    rd_ready = 1'b0;
    test_has_ended = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // Parity entries: {1,0x1} -> 0 and {1,0x3} -> 1 when enabled, else 0.
    applyStimulus(4'd1, 30'h1, 1'b1, 1'b0);
    checkOutput("par_head_a", 64'(rd_parity), 64'(exp_parity(4'd1, 30'h1)));
    applyStimulus(4'd1, 30'h3, 1'b1, 1'b0);
    drain(1);
    checkOutput("par_head_b", 64'(rd_parity), 64'(exp_parity(4'd1, 30'h3)));
    drain(1);
    checkOutput("final_level", 64'(fifo_level), 64'd0);
    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
